instr_mem_responder: RTL and testbench

- Responder end of the CPU instruction-read channel: stores 128-bit segment instructions and answers `cpu_read_valid`/`cpu_read_addr` requests with `cpu_read_data` plus a one-cycle `cpu_read_ack`.
- A host-side write port loads the instruction image before and during operation.
- Sits beside `cpu_top` and drives its `cpu_read_data`/`cpu_read_ack` inputs.

---
 rtl/instr_mem_pkg.sv | 14 +
 rtl/instr_mem_responder_if.sv | 25 ++
 rtl/instr_mem_responder_ram.sv | 28 ++
 rtl/instr_mem_responder.sv | 120 ++++++++++++
 tb/tb_instr_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// Shared widths and FSM encoding for the instruction-memory responder.
package instr_mem_pkg;

  localparam int INSTR_W         = 128;
  localparam int CPU_ADDR_W      = 33;
  localparam int WORD_BYTES_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// CPU instruction-read channel plus host write port, bundled for the responder.
interface instr_mem_responder_if #(
  parameter int ADDR_W = 8
);

  logic                                cpu_read_valid;
  logic [instr_mem_pkg::CPU_ADDR_W-1:0] cpu_read_addr;
  logic [instr_mem_pkg::INSTR_W-1:0]    cpu_read_data;
  logic                                cpu_read_ack;
  logic                                wr_valid;
  logic [ADDR_W-1:0]                   wr_addr;
  logic [instr_mem_pkg::INSTR_W-1:0]    wr_data;
  logic                                wr_ready;

  modport master (
    output cpu_read_valid, cpu_read_addr, wr_valid, wr_addr, wr_data,
    input  cpu_read_data, cpu_read_ack, wr_ready
  );

  modport slave (
    input  cpu_read_valid, cpu_read_addr, wr_valid, wr_addr, wr_data,
    output cpu_read_data, cpu_read_ack, wr_ready
  );

endinterface

// File: rtl/instr_mem_responder_ram.sv
// Simple dual-port instruction RAM: registered read, old data wins on a
// same-address read/write collision. The array itself is never reset.
module instr_mem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Responder for CPU instruction fetches: one request at a time, fixed
// latency RD_LAT, sticky out-of-range flag and a completed-read counter.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_mem_responder_if.slave   bus,
  output logic                   busy,
  output logic                   rd_err,
  output logic [31:0]            rd_count
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t              state_reg, state_next;
  logic [1:0]          lat_cnt_reg, lat_cnt_next;
  logic                live_reg;
  logic                oor_reg;
  logic                rd_err_reg;
  logic [31:0]         rd_count_reg;
  logic                accept;
  logic                req_oor;
  logic                wr_en;
  logic [ADDR_W-1:0]   rd_idx;
  logic [INSTR_W-1:0]  ram_dout;

  assign rd_idx  = bus.cpu_read_addr[ADDR_W+WORD_BYTES_LOG2-1:WORD_BYTES_LOG2];
  assign req_oor = |bus.cpu_read_addr[CPU_ADDR_W-1:ADDR_W+WORD_BYTES_LOG2];
  // live_reg holds everything off for the first cycle after a reset edge
  assign accept  = (state_reg == IDLE) && live_reg && bus.cpu_read_valid;
  assign wr_en   = bus.wr_valid && live_reg;

  instr_mem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (accept),
    .rd_addr (rd_idx),
    .rd_data (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (RD_LAT == 1) begin
            state_next = ACK;
          end else begin
            state_next   = WAIT;
            lat_cnt_next = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        lat_cnt_next = lat_cnt_reg - 2'd1;
        if (lat_cnt_reg == 2'd1) begin
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_reg     <= 1'b0;
      oor_reg      <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_count_reg <= '0;
    end else begin
      live_reg <= 1'b1;
      if (accept) begin
        oor_reg <= req_oor;
        if (req_oor) begin
          rd_err_reg <= 1'b1;
        end
      end
      if (state_reg == ACK) begin
        rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

  always_comb begin
    bus.cpu_read_ack  = (state_reg == ACK);
    bus.cpu_read_data = '0;
    if ((state_reg == ACK) && !oor_reg) begin
      bus.cpu_read_data = ram_dout;
    end
    bus.wr_ready = live_reg;
    busy = live_reg && (((state_reg == IDLE) && bus.cpu_read_valid) || (state_reg == WAIT));
  end

  assign rd_err   = rd_err_reg;
  assign rd_count = rd_count_reg;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder at RD_LAT 1, 3 and 4, checked every
// cycle against a request-schedule model plus literal expectations.
module tb_instr_mem_responder;

  logic         clk;
  logic         rst;
  logic         rv [3];
  logic [32:0]  ra [3];
  logic         wv;
  logic [7:0]   wa;
  logic [127:0] wd;

  logic         ack_o  [3];
  logic [127:0] data_o [3];
  logic         busy_o [3];
  logic         err_o  [3];
  logic         rdy_o  [3];
  logic [31:0]  cnt_o  [3];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] W2 = 128'h22222222_AAAAAAAA_55555555_00000002;
  localparam logic [127:0] W3 = 128'h33333333_CCCCCCCC_0F0F0F0F_00000003;
  localparam logic [127:0] WA = 128'hAAAA0000_00000000_00000000_0000AAAA;
  localparam logic [127:0] WB = 128'hBBBB1111_22223333_44445555_6666BBBB;
  localparam logic [127:0] W6 = 128'h66666666_12345678_9ABCDEF0_00000006;

  instr_mem_responder_if #(.ADDR_W(8)) b1 ();
  instr_mem_responder_if #(.ADDR_W(8)) b3 ();
  instr_mem_responder_if #(.ADDR_W(8)) b4 ();

  assign b1.cpu_read_valid = rv[0];
  assign b1.cpu_read_addr  = ra[0];
  assign b1.wr_valid       = wv;
  assign b1.wr_addr        = wa;
  assign b1.wr_data        = wd;
  assign b3.cpu_read_valid = rv[1];
  assign b3.cpu_read_addr  = ra[1];
  assign b3.wr_valid       = wv;
  assign b3.wr_addr        = wa;
  assign b3.wr_data        = wd;
  assign b4.cpu_read_valid = rv[2];
  assign b4.cpu_read_addr  = ra[2];
  assign b4.wr_valid       = wv;
  assign b4.wr_addr        = wa;
  assign b4.wr_data        = wd;

  assign ack_o[0] = b1.cpu_read_ack;
  assign ack_o[1] = b3.cpu_read_ack;
  assign ack_o[2] = b4.cpu_read_ack;
  assign data_o[0] = b1.cpu_read_data;
  assign data_o[1] = b3.cpu_read_data;
  assign data_o[2] = b4.cpu_read_data;
  assign rdy_o[0] = b1.wr_ready;
  assign rdy_o[1] = b3.wr_ready;
  assign rdy_o[2] = b4.wr_ready;

  instr_mem_responder #(.DEPTH(256), .ADDR_W(8), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy_o[0]), .rd_err(err_o[0]), .rd_count(cnt_o[0]));
  instr_mem_responder #(.DEPTH(256), .ADDR_W(8), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .bus(b3), .busy(busy_o[1]), .rd_err(err_o[1]), .rd_count(cnt_o[1]));
  instr_mem_responder #(.DEPTH(256), .ADDR_W(8), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .bus(b4), .busy(busy_o[2]), .rd_err(err_o[2]), .rd_count(cnt_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: each accepted request is a scheduled response
  int           lat_of [3] = '{1, 3, 4};
  longint       cyc = 0;
  bit           m_on = 1'b0;
  bit           m_live = 1'b0;
  bit           m_pend [3];
  longint       m_due [3];
  logic [127:0] m_pdata [3];
  bit           m_err [3];
  int unsigned  m_cnt [3];
  logic [127:0] m_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 1'b0; m_due[k] = 0; m_pdata[k] = '0; m_err[k] = 1'b0; m_cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_pend[k] = 1'b0;
        m_err[k]  = 1'b0;
        m_cnt[k]  = 0;
      end
      m_live = 1'b0;
      m_on   = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_pend[k] && m_due[k] == cyc) begin
          m_pend[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 1;
        end else if (!m_pend[k] && m_live && rv[k]) begin
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + lat_of[k];
          if (ra[k][32:12] != 21'd0) begin
            m_pdata[k] = '0;
            m_err[k]   = 1'b1;
          end else begin
            m_pdata[k] = m_mem[ra[k][11:4]];
          end
        end
      end
      if (m_live && wv) m_mem[wa] = wd;
      m_live = 1'b1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_on) begin
      for (int k = 0; k < 3; k++) begin
        logic e_ack, e_busy;
        e_ack  = m_pend[k] && (m_due[k] == cyc);
        e_busy = m_live && ((!m_pend[k] && rv[k]) || (m_pend[k] && !e_ack));
        chk($sformatf("m_ack%0d", k),  128'(ack_o[k]),  128'(e_ack));
        chk($sformatf("m_data%0d", k), data_o[k],       e_ack ? m_pdata[k] : 128'd0);
        chk($sformatf("m_busy%0d", k), 128'(busy_o[k]), 128'(e_busy));
        chk($sformatf("m_err%0d", k),  128'(err_o[k]),  128'(m_err[k]));
        chk($sformatf("m_cnt%0d", k),  128'(cnt_o[k]),  128'(m_cnt[k]));
        chk($sformatf("m_rdy%0d", k),  128'(rdy_o[k]),  128'(m_live));
      end
    end
  end

  // ---------------- directed stimulus
  task automatic cyc_go();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [127:0] d);
    wv = 1'b1; wa = idx; wd = d;
    cyc_go();
    wv = 1'b0;
  endtask

  // Call in the request cycle T; returns in cycle T+lat+1.
  task automatic await_ack(input int k, input int lat, input logic [127:0] d, input string nm);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk({nm, "_noack"}, 128'(ack_o[k]), 128'd0);
      chk({nm, "_busy"},  128'(busy_o[k]), 128'd1);
      cyc_go();
    end
    @(negedge clk);
    chk({nm, "_ack"},     128'(ack_o[k]), 128'd1);
    chk({nm, "_data"},    data_o[k], d);
    chk({nm, "_ackbusy"}, 128'(busy_o[k]), 128'd0);
    cyc_go();
  endtask

  initial begin
    rst = 1'b0; wv = 1'b0; wa = '0; wd = '0;
    for (int k = 0; k < 3; k++) begin rv[k] = 1'b0; ra[k] = '0; end
    cyc_go(); cyc_go();
    @(negedge clk);
    chk("rst_ready", 128'(rdy_o[0]), 128'd0);
    chk("rst_data",  data_o[2], 128'd0);
    chk("rst_cnt",   128'(cnt_o[1]), 128'd0);
    cyc_go();
    rst = 1'b1;
    cyc_go();
    @(negedge clk);
    chk("rel_ready", 128'(rdy_o[0]), 128'd1);
    cyc_go();

    // 1: LAT=1 read of word 1
    wr(8'd1, W1);
    rv[0] = 1'b1; ra[0] = 33'h010;
    await_ack(0, 1, W1, "t1");
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t1_cnt",   128'(cnt_o[0]), 128'd1);
    chk("t1_data0", data_o[0], 128'd0);
    chk("t1_ack0",  128'(ack_o[0]), 128'd0);
    cyc_go();

    // 2: LAT=3 back-to-back reads of words 2 then 3
    wr(8'd2, W2);
    wr(8'd3, W3);
    rv[1] = 1'b1; ra[1] = 33'h020;
    await_ack(1, 3, W2, "t2a");
    ra[1] = 33'h030;
    await_ack(1, 3, W3, "t2b");
    rv[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_nodup", 128'(ack_o[1]), 128'd0);
      cyc_go();
    end
    @(negedge clk);
    chk("t2_cnt", 128'(cnt_o[1]), 128'd2);
    cyc_go();

    // 3: out-of-range then a valid read; rd_err sticks
    rv[0] = 1'b1; ra[0] = 33'h1_0000_0000;
    await_ack(0, 1, 128'd0, "t3oor");
    ra[0] = 33'h010;
    await_ack(0, 1, W1, "t3ok");
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t3_err", 128'(err_o[0]), 128'd1);
    cyc_go();

    // 4: write collides with the read issue cycle -> old data returned
    wr(8'd5, WA);
    rv[0] = 1'b1; ra[0] = 33'h050;
    wv = 1'b1; wa = 8'd5; wd = WB;
    @(negedge clk);
    chk("t4_busy", 128'(busy_o[0]), 128'd1);
    cyc_go();
    wv = 1'b0;
    @(negedge clk);
    chk("t4_ack",  128'(ack_o[0]), 128'd1);
    chk("t4_old",  data_o[0], WA);
    cyc_go();
    await_ack(0, 1, WB, "t4new");
    rv[0] = 1'b0;
    cyc_go();

    // 5: LAT=4, reset during WAIT drops the request; memory survives
    wr(8'd6, W6);
    rv[2] = 1'b1; ra[2] = 33'h060;
    cyc_go(); cyc_go();
    rst = 1'b0;
    cyc_go();
    rst = 1'b1; rv[2] = 1'b0;
    @(negedge clk);
    chk("t5_ack",  128'(ack_o[2]), 128'd0);
    chk("t5_data", data_o[2], 128'd0);
    chk("t5_busy", 128'(busy_o[2]), 128'd0);
    chk("t5_err",  128'(err_o[2]), 128'd0);
    chk("t5_cnt",  128'(cnt_o[2]), 128'd0);
    chk("t5_rdy",  128'(rdy_o[2]), 128'd0);
    cyc_go();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_noack", 128'(ack_o[2]), 128'd0);
      cyc_go();
    end
    rv[2] = 1'b1; ra[2] = 33'h060;
    await_ack(2, 4, W6, "t5re");
    rv[2] = 1'b0;
    cyc_go();

    // 6: misaligned byte address maps to word 1, no error
    rv[0] = 1'b1; ra[0] = 33'h01F;
    await_ack(0, 1, W1, "t6");
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t6_err", 128'(err_o[0]), 128'd0);
    cyc_go();

    // 7: LAT=4, address change and valid drop during WAIT are ignored
    rv[2] = 1'b1; ra[2] = 33'h020;
    cyc_go();
    ra[2] = 33'h030;
    cyc_go();
    rv[2] = 1'b0;
    cyc_go(); cyc_go();
    @(negedge clk);
    chk("t7_ack",  128'(ack_o[2]), 128'd1);
    chk("t7_data", data_o[2], W2);
    cyc_go();
    @(negedge clk);
    chk("t7_cnt", 128'(cnt_o[2]), 128'd2);
    cyc_go(); cyc_go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
